// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between two requesters.
//
// Each requester issues a one-cycle mask pulse. The request is buffered in a
// per-port pending slot, the slots are arbitrated round-robin, and one request
// is issued downstream at a time. The completion is routed back to its owner.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   pN_addr/rmask/wmask/wdata     requester N request (mask nonzero = request pulse)
//   pN_rdata, pN_resp             requester N completion pulse and read data
//   mem_addr/rmask/wmask/wdata    downstream request (masks nonzero for one cycle)
//   mem_rdata, mem_resp           downstream completion
//   busy                          transaction outstanding or request pending
//   proto_err                     one-cycle pulse after a request is dropped
//
// Build option: define ARB_FIXED_PRIO_EN to make port 0 always win ties.
module dmem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W/8-1:0] p0_rmask,
    input  logic [DATA_W/8-1:0] p0_wmask,
    input  logic [DATA_W-1:0]   p0_wdata,
    output logic [DATA_W-1:0]   p0_rdata,
    output logic                p0_resp,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W/8-1:0] p1_rmask,
    input  logic [DATA_W/8-1:0] p1_wmask,
    input  logic [DATA_W-1:0]   p1_wdata,
    output logic [DATA_W-1:0]   p1_rdata,
    output logic                p1_resp,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_rmask,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp,
    output logic                busy,
    output logic                proto_err
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state, state_nx;
    logic [1:0]          pend_v;
    logic [ADDR_W-1:0]   pend_addr  [2];
    logic [DATA_W/8-1:0] pend_rmask [2];
    logic [DATA_W/8-1:0] pend_wmask [2];
    logic [DATA_W-1:0]   pend_wdata [2];
    logic [ADDR_W-1:0]   req_addr   [2];
    logic [DATA_W/8-1:0] req_rmask  [2];
    logic [DATA_W/8-1:0] req_wmask  [2];
    logic [DATA_W-1:0]   req_wdata  [2];
    logic [1:0]          req, drop;
    logic [ADDR_W-1:0]   last_addr;
    logic [DATA_W-1:0]   last_wdata;
    logic                prio, owner, win, grant, done;

    assign req_addr[0]  = p0_addr;
    assign req_addr[1]  = p1_addr;
    assign req_rmask[0] = p0_rmask;
    assign req_rmask[1] = p1_rmask;
    assign req_wmask[0] = p0_wmask;
    assign req_wmask[1] = p1_wmask;
    assign req_wdata[0] = p0_wdata;
    assign req_wdata[1] = p1_wdata;

    always_comb begin
        state_nx = state;
        done     = (state == WAIT) && mem_resp;
        grant    = (state == IDLE) && (|pend_v);
`ifdef ARB_FIXED_PRIO_EN
        win      = ~pend_v[0];
`else
        win      = (&pend_v) ? prio : pend_v[1];
`endif
        state_nx = grant ? WAIT : done ? IDLE : state;
        for (int n = 0; n < 2; n++) begin
            req[n]  = |{req_rmask[n], req_wmask[n]};
            // The owner is released in its response cycle, so a new request then is legal.
            drop[n] = req[n] && (pend_v[n] || ((state == WAIT) && (owner == 1'(n)) && !done));
        end
    end

    assign mem_addr  = grant ? pend_addr[win]  : last_addr;
    assign mem_wdata = grant ? pend_wdata[win] : last_wdata;
    assign mem_rmask = grant ? pend_rmask[win] : '0;
    assign mem_wmask = grant ? pend_wmask[win] : '0;
    assign p0_resp   = done && !owner;
    assign p1_resp   = done && owner;
    assign p0_rdata  = p0_resp ? mem_rdata : '0;
    assign p1_rdata  = p1_resp ? mem_rdata : '0;
    assign busy      = (state == WAIT) || (|pend_v);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_v     <= '0;
            prio       <= 1'b0;
            owner      <= 1'b0;
            last_addr  <= '0;
            last_wdata <= '0;
            proto_err  <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                pend_addr[n]  <= '0;
                pend_rmask[n] <= '0;
                pend_wmask[n] <= '0;
                pend_wdata[n] <= '0;
            end
        end else begin
            proto_err <= |drop;
            if (grant) begin
                owner      <= win;
`ifndef ARB_FIXED_PRIO_EN
                prio       <= ~win;
`endif
                last_addr  <= mem_addr;
                last_wdata <= mem_wdata;
            end
            // A request on the winning port is always dropped (its slot is still
            // valid), so capture and clear never collide on one slot.
            for (int n = 0; n < 2; n++) begin
                if (req[n] && !drop[n]) begin
                    pend_v[n]     <= 1'b1;
                    pend_addr[n]  <= req_addr[n];
                    pend_rmask[n] <= req_rmask[n];
                    pend_wmask[n] <= req_wmask[n];
                    pend_wdata[n] <= req_wdata[n];
                end else if (grant && (win == 1'(n))) begin
                    pend_v[n] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: self-checking bench for dmem_port_arbiter.
module tb_dmem_port_arbiter;
    logic        clk, rst;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata, p0_rdata, p1_rdata;
    logic [3:0]  p0_rmask, p1_rmask, p0_wmask, p1_wmask;
    logic        p0_resp, p1_resp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_rmask, mem_wmask;
    logic        mem_resp, busy, proto_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] wd;
    } iss_t;

    typedef struct {
        bit          port;
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          dly;
        logic [31:0] exp_rdata;
    } vec_t;

    iss_t q[$];
    vec_t vecs[4];

    dmem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_rmask(p0_rmask), .p0_wmask(p0_wmask), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_resp(p0_resp),
        .p1_addr(p1_addr), .p1_rmask(p1_rmask), .p1_wmask(p1_wmask), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_resp(p1_resp),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit p, input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd);
        if (p) begin
            p1_addr = a; p1_rmask = rm; p1_wmask = wm; p1_wdata = wd;
        end else begin
            p0_addr = a; p0_rmask = rm; p0_wmask = wm; p0_wdata = wd;
        end
    endtask

    task automatic clr();
        p0_rmask = '0; p0_wmask = '0; p1_rmask = '0; p1_wmask = '0;
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd);
        iss_t e;
        e.addr = a; e.rm = rm; e.wm = wm; e.wd = wd;
        q.push_back(e);
    endtask

    // Scoreboard: every downstream issue must match the oldest expected one.
    always @(negedge clk) begin
        iss_t e;
        if (rst && (mem_rmask != 0 || mem_wmask != 0)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h expected=none at %0t", mem_addr, $time);
            end else begin
                e = q.pop_front();
                chk("sb_addr", mem_addr, e.addr);
                chk("sb_rmask", mem_rmask, e.rm);
                chk("sb_wmask", mem_wmask, e.wm);
                if (e.wm != 0) chk("sb_wdata", mem_wdata, e.wd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    bit ord[5];
    logic [31:0] fa;

    initial begin
        vecs[0] = '{0, 32'h100, 4'hF, 4'h0, 32'h0,        32'hDEADBEEF, 2, 32'hDEADBEEF};
        vecs[1] = '{1, 32'h140, 4'h0, 4'hC, 32'hCAFE0000, 32'h55AA55AA, 0, 32'h55AA55AA};
        vecs[2] = '{1, 32'h180, 4'h1, 4'h0, 32'h0,        32'h000000FF, 3, 32'h000000FF};
        vecs[3] = '{0, 32'h1C0, 4'h3, 4'h3, 32'h0BADF00D, 32'h12345678, 1, 32'h12345678};
`ifdef ARB_FIXED_PRIO_EN
        ord = '{0, 0, 0, 0, 1};
`else
        ord = '{0, 1, 0, 1, 0};
`endif
        rst = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
        clr();
        #3;
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_masks", {mem_rmask, mem_wmask}, 0);
        chk("rst_flags", {busy, proto_err, p0_resp, p1_resp}, 0);
        step();
        rst = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 4; i++) begin
            step();
            req(vecs[i].port, vecs[i].addr, vecs[i].rmask, vecs[i].wmask, vecs[i].wdata);
            push(vecs[i].addr, vecs[i].rmask, vecs[i].wmask, vecs[i].wdata);
            step();
            clr();
            #1;
            chk("vec_issue_masks", {mem_rmask, mem_wmask}, {vecs[i].rmask, vecs[i].wmask});
            chk("vec_issue_addr", mem_addr, vecs[i].addr);
            step();
            chk("vec_wait_masks", {mem_rmask, mem_wmask}, 0);
            chk("vec_wait_hold", mem_addr, vecs[i].addr);
            chk("vec_wait_busy", busy, 1);
            repeat (vecs[i].dly) step();
            mem_resp = 1'b1;
            mem_rdata = vecs[i].mrdata;
            #1;
            chk("vec_resp", {p1_resp, p0_resp}, vecs[i].port ? 2'b10 : 2'b01);
            chk("vec_rdata", vecs[i].port ? p1_rdata : p0_rdata, vecs[i].exp_rdata);
            chk("vec_other_rdata", vecs[i].port ? p0_rdata : p1_rdata, 0);
            step();
            mem_resp = 1'b0;
            #1;
            chk("vec_after", {busy, p0_resp, p1_resp}, 0);
        end

        // Simultaneous requests after reset
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        step();
        req(0, 32'h200, 4'hF, 4'h0, 32'h0);
        req(1, 32'h300, 4'h0, 4'h3, 32'h1234);
        push(32'h200, 4'hF, 4'h0, 32'h0);
        push(32'h300, 4'h0, 4'h3, 32'h1234);
        step();
        clr();
        #1;
        chk("sim_p0_first", {mem_addr, mem_rmask}, {32'h200, 4'hF});
        step();
        chk("sim_busy", busy, 1);
        step();
        mem_resp = 1'b1;
        #1;
        chk("sim_p0_resp", {p1_resp, p0_resp}, 2'b01);
        chk("sim_no_issue_in_resp", {mem_rmask, mem_wmask}, 0);
        step();
        mem_resp = 1'b0;
        #1;
        chk("sim_p1_issue", {mem_addr, mem_wmask, mem_wdata}, {32'h300, 4'h3, 32'h1234});
        step();
        mem_resp = 1'b1;
        #1;
        chk("sim_p1_resp", {p1_resp, p0_resp}, 2'b10);
        step();
        mem_resp = 1'b0;

        // Fairness: both ports keep requesting
        step();
        req(0, 32'h1000, 4'hF, 4'h0, 32'h0);
        req(1, 32'h2000, 4'h0, 4'hF, 32'hAAAA);
        step();
        clr();
        for (int r = 0; r < 5; r++) begin
            fa = ord[r] ? 32'h2000 : 32'h1000;
            push(fa, ord[r] ? 4'h0 : 4'hF, ord[r] ? 4'hF : 4'h0, 32'hAAAA);
            #1;
            chk("fair_grant", mem_addr, fa);
            step();
            mem_resp = 1'b1;
            mem_rdata = 32'(r);
            if (r < 3) req(ord[r], fa, ord[r] ? 4'h0 : 4'hF, ord[r] ? 4'hF : 4'h0, 32'hAAAA);
            #1;
            chk("fair_resp", {p1_resp, p0_resp}, ord[r] ? 2'b10 : 2'b01);
            chk("fair_no_err", proto_err, 0);
            step();
            clr();
            mem_resp = 1'b0;
        end
        #1;
        chk("fair_drained", busy, 0);

        // Drop: second p0 request while p0 owns the port
        step();
        req(0, 32'h400, 4'hF, 4'h0, 32'h0);
        push(32'h400, 4'hF, 4'h0, 32'h0);
        step();
        clr();
        #1;
        chk("drop_issue", {mem_addr, mem_rmask}, {32'h400, 4'hF});
        step();
        req(0, 32'h500, 4'hF, 4'h0, 32'h0);
        step();
        clr();
        #1;
        chk("drop_err_pulse", proto_err, 1);
        step();
        chk("drop_err_once", proto_err, 0);
        mem_resp = 1'b1;
        #1;
        chk("drop_resp", {p1_resp, p0_resp}, 2'b01);
        step();
        mem_resp = 1'b0;
        #1;
        chk("drop_no_reissue", {busy, mem_rmask, mem_wmask}, 0);
        step();
        chk("drop_idle", {busy, mem_rmask, mem_wmask}, 0);

        // Stray response while idle
        mem_resp = 1'b1;
        mem_rdata = 32'hFFFF0000;
        #1;
        chk("stray_resp", {p0_resp, p1_resp, busy}, 0);
        chk("stray_rdata", {p0_rdata, p1_rdata}, 0);
        step();
        mem_resp = 1'b0;
        #1;
        chk("stray_idle", {busy, mem_rmask, mem_wmask}, 0);

        // Asynchronous reset during WAIT
        step();
        req(1, 32'h600, 4'h1, 4'h0, 32'h0);
        push(32'h600, 4'h1, 4'h0, 32'h0);
        step();
        clr();
        #1;
        chk("arst_issue", {mem_addr, mem_rmask}, {32'h600, 4'h1});
        step();
        #2 rst = 1'b0;
        #1;
        chk("arst_addr", mem_addr, 0);
        chk("arst_flags", {busy, proto_err, p0_resp, p1_resp, mem_rmask, mem_wmask}, 0);
        step();
        rst = 1'b1;
        mem_resp = 1'b1;
        mem_rdata = 32'h77;
        #1;
        chk("arst_late_resp", {p0_resp, p1_resp, p1_rdata}, 0);
        step();
        mem_resp = 1'b0;
        req(1, 32'h700, 4'h0, 4'h5, 32'h99);
        push(32'h700, 4'h0, 4'h5, 32'h99);
        step();
        clr();
        #1;
        chk("arst_new_issue", {mem_addr, mem_wmask, mem_wdata}, {32'h700, 4'h5, 32'h99});
        step();
        mem_resp = 1'b1;
        #1;
        chk("arst_new_resp", {p1_resp, p0_resp}, 2'b10);
        step();
        mem_resp = 1'b0;
        step();
        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares one data-memory port between two requesters. Requester 0 is the load/store memory controller; requester 1 is a secondary master such as a prefetcher or debug unit. Each requester uses the codebase's single-cycle mask-pulse request / resp-pulse completion protocol. Requests are buffered, arbitrated round-robin, and issued one at a time; each response is routed back to its owner.

Parameters:
ADDR_W, 32, width of every address port.
DATA_W, 32, width of data ports; mask width is DATA_W/8.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
p0_addr / p1_addr  in  ADDR_W  request address, word aligned.
p0_rmask / p1_rmask  in  DATA_W/8  read byte mask; nonzero for one cycle = read request.
p0_wmask / p1_wmask  in  DATA_W/8  write byte mask; nonzero for one cycle = write request.
p0_wdata / p1_wdata  in  DATA_W  write data.
p0_rdata / p1_rdata  out  DATA_W  response data; 0 when the matching resp is low.
p0_resp / p1_resp  out  1  one-cycle completion pulse.
mem_addr  out  ADDR_W  downstream address.
mem_rmask  out  DATA_W/8  downstream read mask.
mem_wmask  out  DATA_W/8  downstream write mask.
mem_wdata  out  DATA_W  downstream write data.
mem_rdata  in  DATA_W  downstream read data.
mem_resp  in  1  downstream completion pulse.
busy  out  1  high in WAIT or whenever any pending slot is valid.
proto_err  out  1  one-cycle pulse when a request is dropped.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, both pending slots invalid, prio=0, owner=0.
  - All outputs 0.
- Capture: a request on pN (rmask|wmask != 0) is latched at the clock edge into pend_N (addr, rmask, wmask, wdata) and sets pend_N valid.
  - Capture is independent of arbiter state.
- Drop rule: a new pN request while pend_N is valid, or while state=WAIT with owner=N, is discarded.
  - proto_err pulses the next cycle; existing state is unchanged.
- Both masks nonzero in the same request: captured as given and forwarded unchanged. The downstream defines the result.
- IDLE with at least one pending slot valid:
  - Winner = the only valid slot, or slot prio if both are valid.
  - Same cycle: drive mem_addr, mem_wdata, mem_rmask, mem_wmask from the winner's slot; masks are nonzero for exactly this cycle.
  - Edge: clear the winner's valid bit, owner<=winner, prio<=~winner, state<=WAIT.
  - Latency from request pulse to downstream issue: 1 cycle.
- IDLE with nothing pending: masks 0; mem_addr and mem_wdata hold their last values.
- WAIT:
  - Masks 0; mem_addr and mem_wdata held stable.
  - On mem_resp: p<owner>_resp=1 and p<owner>_rdata=mem_rdata combinationally in the same cycle; the other port's resp is 0. State<=IDLE.
  - The next grant issues in the cycle after mem_resp.
- mem_resp while IDLE: ignored, no resp routed.
- Capture and grant in the same cycle: a new request on the non-winning port is captured normally.
- A response and a new request from the same port in the same cycle are legal, since the owner is released that cycle.
- Reset mid-WAIT: the outstanding transaction is abandoned. A mem_resp arriving after reset falls under the IDLE rule and is ignored.
- Write completions: pN_resp pulses; pN_rdata carries mem_rdata, and the requester ignores it.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: port 0 always wins when both slots are valid; prio is unused and held at 0.
- Undefined: round-robin as described above.

Test Plan:
- Single read: p0 read, addr 0x100, rmask 0xF at T -> mem_rmask 0xF at T+1 only. mem_resp at T+4 with rdata 0xDEADBEEF -> p0_resp=1 and p0_rdata=0xDEADBEEF at T+4, p1_resp=0.
- Simultaneous requests after reset: p0 read 0x200 and p1 write 0x300 (wmask 0x3, wdata 0x1234) at T -> p0 issued at T+1. After p0's resp, p1 issued the next cycle with mem_wmask 0x3 and mem_wdata 0x1234.
- Fairness: both ports request continuously for 4 rounds -> grant order 0,1,0,1. With ARB_FIXED_PRIO_EN -> 0,0,0,0 while p0 is always pending.
- Drop: p0 request, then a second p0 request before its resp -> proto_err pulses once; exactly one downstream issue for p0.
- Stray response: mem_resp=1 with no outstanding transaction -> p0_resp=p1_resp=0, state stays IDLE, busy=0.
- Async reset during WAIT: rst low mid-transaction -> all outputs 0 immediately. A later mem_resp is ignored; a new p1 request issues 1 cycle after its pulse.
